// File: rtl/phase_readout_pkg.sv
// -----------------------------------------------------------------------------
// phase_readout_pkg
//   Shared definitions for the phase readout blocks: the measurement FSM
//   state encoding and the default synchronizer depth used by both the top
//   level (reference oscillator) and every per-spin phase_counter.
//
//   Contents:
//     SYNC_STAGES_DEFAULT : default flop depth of each oscillator synchronizer
//     state_t             : IDLE / SETTLE / MEASURE / DONE encoding
// -----------------------------------------------------------------------------
package phase_readout_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
//   One spin channel: synchronizes the asynchronous spin oscillator phase and
//   counts the cycles in which it disagrees with the (already synchronized)
//   reference phase.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rstn       in   asynchronous active-low reset (clears sync chain, count)
//     osc        in   asynchronous spin oscillator phase
//     ref_sync   in   synchronized reference phase from the top level
//     clear      in   zero the counter on this edge (wins over enable)
//     enable     in   count mismatches on this edge
//     count_next out  value the counter takes on the next edge; the top level
//                     samples it on the edge that ends the measurement so the
//                     final mismatch cycle is included in the result
// -----------------------------------------------------------------------------
module phase_counter
    import phase_readout_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             osc,
    input  logic             ref_sync,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_next
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count_q;
    logic                   mismatch;

    // Plain shift chain; only the last stage is ever looked at.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= osc;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign mismatch = sync_q[SYNC_STAGES-1] ^ ref_sync;

    // The measurement window never exceeds the counter range, so the
    // all-ones guard never fires in normal use; it only makes a wrap
    // impossible by construction.
    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (enable && mismatch && (count_q != '1)) begin
            count_next = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/phase_readout.sv
// -----------------------------------------------------------------------------
// phase_readout
//   Measures NUM_SPINS asynchronous spin oscillators against a reference
//   oscillator. After a start request the block settles its synchronizers,
//   counts per-spin phase mismatches for `window` cycles, then decodes each
//   spin as 1 when it disagreed with the reference for more than half of the
//   window (a tie decodes as 0).
//
//   Ports:
//     clk       in   system clock, rising edge
//     rstn      in   asynchronous active-low reset, aborts any measurement
//     start     in   measurement request, sampled only while idle
//     window    in   measurement length in cycles, latched on accepted start
//     ref_osc   in   asynchronous reference oscillator phase
//     spin_osc  in   asynchronous spin oscillator phases
//     cnt_sel   in   selects which spin's last result drives cnt_out
//     busy      out  high whenever a measurement is in progress
//     done      out  one-cycle pulse in the cycle results become visible
//     spin_out  out  decoded spin values, held until the next measurement ends
//     cnt_out   out  last completed mismatch count of spin cnt_sel
//
//   Request protocol: start is a level, not a handshake. It is accepted on any
//   rising edge where the FSM is IDLE (busy=0) and is ignored otherwise; there
//   is no queuing. Holding start high re-arms a new run in the IDLE cycle that
//   follows each DONE.
//
//   Timeline from the accepting edge: SETTLE for SYNC_STAGES+1 cycles (one
//   cycle for the window latch / counter clear to land plus SYNC_STAGES to
//   flush the synchronizers), MEASURE for `window` cycles, then DONE, so done
//   rises 1+SYNC_STAGES+window cycles after acceptance.
// -----------------------------------------------------------------------------
module phase_readout
    import phase_readout_pkg::*;
#(
    parameter int  NUM_SPINS   = 8,
    parameter int  CNT_W       = 16,
    parameter int  SYNC_STAGES = SYNC_STAGES_DEFAULT,
    localparam int SEL_W       = (NUM_SPINS > 1) ? $clog2(NUM_SPINS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CNT_W-1:0]     window,
    input  logic                 ref_osc,
    input  logic [NUM_SPINS-1:0] spin_osc,
    input  logic [SEL_W-1:0]     cnt_sel,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SPINS-1:0] spin_out,
    output logic [CNT_W-1:0]     cnt_out
);

    localparam int              SET_W       = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SYNC_STAGES);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]     window_q;
    logic [SET_W-1:0]     settle_q;
    logic [CNT_W-1:0]     meas_q;
    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic [CNT_W-1:0]     result_q [NUM_SPINS];
    logic [NUM_SPINS-1:0] spin_q;

    logic settle_last;
    logic meas_last;
    logic clear_cnt;
    logic enable_cnt;
    logic load_res;

    logic [NUM_SPINS-1:0][CNT_W-1:0] cnt_next;

    // ------------------------------------------------------------------
    // Reference synchronizer (spin synchronizers live in phase_counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_sync_q <= '0;
        end else begin
            ref_sync_q[0] <= ref_osc;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                ref_sync_q[s] <= ref_sync_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-spin mismatch counters
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SPINS; i++) begin : g_spin
        phase_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_counter (
            .clk        (clk),
            .rstn       (rstn),
            .osc        (spin_osc[i]),
            .ref_sync   (ref_sync_q[SYNC_STAGES-1]),
            .clear      (clear_cnt),
            .enable     (enable_cnt),
            .count_next (cnt_next[i])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEASURE is only entered with a non-zero window, so window_q-1 cannot
    // underflow while meas_last matters.
    assign settle_last = (settle_q == SETTLE_LAST);
    assign meas_last   = (meas_q == (window_q - CNT_W'(1)));

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_d = (window_q == '0) ? ST_DONE : ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (meas_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        clear_cnt  = (state_q == ST_IDLE) && start;
        enable_cnt = (state_q == ST_MEASURE);
        load_res   = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // ------------------------------------------------------------------
    // Window latch, phase timers, results and decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            window_q <= '0;
            settle_q <= '0;
            meas_q   <= '0;
            spin_q   <= '0;
            for (int i = 0; i < NUM_SPINS; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            if (clear_cnt) begin
                window_q <= window;
            end

            if (state_q == ST_SETTLE) begin
                settle_q <= settle_q + SET_W'(1);
            end else begin
                settle_q <= '0;
            end

            if (state_q == ST_MEASURE) begin
                meas_q <= meas_q + CNT_W'(1);
            end else begin
                meas_q <= '0;
            end

            // cnt_next already includes the last MEASURE cycle's increment.
            // Majority test 2*count > window, done one bit wider so the
            // doubled count cannot overflow; a tie decodes as 0.
            if (load_res) begin
                for (int i = 0; i < NUM_SPINS; i++) begin
                    result_q[i] <= cnt_next[i];
                    spin_q[i]   <= ({cnt_next[i], 1'b0} > {1'b0, window_q});
                end
            end
        end
    end

    assign spin_out = spin_q;

    // Compare-based select keeps out-of-range cnt_sel values (non power-of-two
    // NUM_SPINS) well defined: they read as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_SPINS; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_out = result_q[i];
            end
        end
    end

endmodule

// File: tb/tb_phase_readout.sv
// -----------------------------------------------------------------------------
// tb_phase_readout
//   Self-checking bench for phase_readout. Each run pushes its expected done
//   cycle, decoded spins and selected count into queues when the start is
//   driven; a monitor pops them when done pulses. Per-cycle oscillator
//   stimulus comes from a seeded mismatch pattern so the bench can compute the
//   counts itself: the raw input driven in cycle k after the accepting edge
//   (k = 1 is the cycle right after it) is counted for k = 2 .. window+1.
// -----------------------------------------------------------------------------
module tb_phase_readout;

    localparam int NS    = 8;
    localparam int CW    = 16;
    localparam int SS    = 2;
    localparam int SEL_W = 3;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [CW-1:0]  window = '0;
    logic           ref_osc = 1'b0;
    logic [NS-1:0]  spin_osc = '0;
    logic [SEL_W-1:0] cnt_sel = '0;
    logic           busy;
    logic           done;
    logic [NS-1:0]  spin_out;
    logic [CW-1:0]  cnt_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    phase_readout #(
        .NUM_SPINS   (NS),
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .window   (window),
        .ref_osc  (ref_osc),
        .spin_osc (spin_osc),
        .cnt_sel  (cnt_sel),
        .busy     (busy),
        .done     (done),
        .spin_out (spin_out),
        .cnt_out  (cnt_out)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    int             exp_cyc_q[$];
    logic [NS-1:0]  exp_spin_q[$];
    logic [CW-1:0]  exp_q[$];
    logic [CW-1:0]  last_cnt [NS];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // ---------------- stimulus pattern ----------------
    function automatic bit hash_bit(input int unsigned seed, input int i, input int k);
        int unsigned h;
        h = seed ^ (32'(k) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B);
        h = h ^ (h >> 15);
        h = h * 32'h2C1B3C6D;
        h = h ^ (h >> 12);
        return h[3];
    endfunction

    // mode 0: spin0 matches, spin1 opposes, rest random
    // mode 1: spin0 mismatches 50 of cycles 2..101, spin1 51; cycles 1 and
    //         102+ also mismatch so the window boundaries are exercised
    // mode 2: every spin always mismatches
    // mode 3: all spins random
    function automatic bit mis_bit(input int mode, input int unsigned seed, input int i, input int k);
        case (mode)
            0: return (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : hash_bit(seed, i, k);
            1: return (i == 0) ? !(k >= 52 && k <= 101) :
                      (i == 1) ? !(k >= 53 && k <= 101) : hash_bit(seed, i, k);
            2: return 1'b1;
            default: return hash_bit(seed, i, k);
        endcase
    endfunction

    task automatic drive_osc(input int mode, input int unsigned seed, input int k);
        logic r;
        r = 1'($urandom_range(0, 1));
        ref_osc = r;
        for (int i = 0; i < NS; i++) begin
            spin_osc[i] = r ^ mis_bit(mode, seed, i, k);
        end
    endtask

    // ---------------- monitor ----------------
    int            mon_cyc;
    logic [NS-1:0] mon_spin;
    logic [CW-1:0] mon_cnt;

    always @(negedge clk) begin
        if (rstn && done) begin
            if (exp_cyc_q.size() == 0) begin
                check_val("extra_done", 32'(done), 32'd0);
            end else begin
                mon_cyc  = exp_cyc_q.pop_front();
                mon_spin = exp_spin_q.pop_front();
                mon_cnt  = exp_q.pop_front();
                check_val("done_cycle", 32'(cyc), 32'(mon_cyc));
                check_val("spin_out", 32'(spin_out), 32'(mon_spin));
                check_val("cnt_out_at_done", 32'(cnt_out), 32'(mon_cnt));
                check_val("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_one(input int w, input int mode, input int sel);
        int unsigned   seed;
        int            cnt [NS];
        logic [NS-1:0] es;
        int            c0;
        int            t;
        seed = $urandom;
        t    = 1 + SS + w;
        for (int i = 0; i < NS; i++) begin
            cnt[i] = 0;
            for (int k = 2; k <= w + 1; k++) begin
                if (mis_bit(mode, seed, i, k)) cnt[i]++;
            end
            es[i] = (2 * cnt[i] > w);
        end
        @(negedge clk);
        window  = CW'(w);
        cnt_sel = SEL_W'(sel);
        start   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= t + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                c0 = cyc;
                exp_cyc_q.push_back(c0 + t);
                exp_spin_q.push_back(es);
                exp_q.push_back(CW'(cnt[sel]));
                start  = 1'b0;
                // must not disturb the run already accepted
                window = CW'($urandom_range(0, 65535));
                check_val("busy_after_accept", 32'(busy), 32'd1);
            end
            drive_osc(mode, seed, k);
        end
        for (int i = 0; i < NS; i++) last_cnt[i] = CW'(cnt[i]);
        check_val("idle_after_run", 32'(busy), 32'd0);
    endtask

    task automatic check_all_counts(input string tag);
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            cnt_sel = SEL_W'(i);
            #1;
            check_val(tag, 32'(cnt_out), 32'(last_cnt[i]));
        end
    endtask

    // start held high across two back-to-back runs, all spins mismatching
    task automatic run_held(input int w);
        int t;
        int c0;
        logic [NS-1:0] es;
        t  = 1 + SS + w;
        es = (w > 0) ? '1 : '0;
        @(negedge clk);
        window  = CW'(w);
        cnt_sel = SEL_W'(3);
        start   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * t + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                c0 = cyc;
                exp_cyc_q.push_back(c0 + t);
                exp_spin_q.push_back(es);
                exp_q.push_back(CW'(w));
                exp_cyc_q.push_back(c0 + 2 * t + 2);
                exp_spin_q.push_back(es);
                exp_q.push_back(CW'(w));
            end
            if (cyc == c0 + 2 * t + 2) start = 1'b0;
            drive_osc(2, 0, k);
        end
        for (int i = 0; i < NS; i++) last_cnt[i] = CW'(w);
        check_val("idle_after_held", 32'(busy), 32'd0);
        check_val("held_pending", 32'(exp_cyc_q.size()), 32'd0);
    endtask

    task automatic run_reset_abort();
        @(negedge clk);
        window = CW'(50);
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(negedge clk);
            drive_osc(2, 0, 1);
        end
        rstn = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_spin_out", 32'(spin_out), 32'd0);
        check_val("rst_cnt_out", 32'(cnt_out), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NS; i++) last_cnt[i] = '0;
        check_all_counts("cnt_after_rst");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NS; i++) last_cnt[i] = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_spin_out", 32'(spin_out), 32'd0);
        check_val("reset_cnt_out", 32'(cnt_out), 32'd0);
        rstn = 1'b1;

        run_one(100, 0, 1);
        check_all_counts("cnt_match_oppose");
        run_one(0, 3, 2);
        check_all_counts("cnt_window0");
        run_one(100, 1, 0);
        check_all_counts("cnt_half_window");
        run_one(37, 3, 7);
        run_one(1, 3, 1);
        run_one(2, 3, 4);
        check_all_counts("cnt_short");
        run_one(20, 2, 6);
        run_reset_abort();
        run_one(30, 3, 5);
        check_all_counts("cnt_post_rst");
        run_held(10);
        check_all_counts("cnt_held");
        run_one(65535, 2, 3);
        check_all_counts("cnt_full_window");

        repeat (4) @(negedge clk);
        check_val("pending", 32'(exp_cyc_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
